// File: rtl/memory_access.sv
// Memory-access pipeline stage: byte-addressable data memory with a power-up
// clear sweep, sized loads/stores with sign/zero extension, and a debug read port.
module memory_access #(
  parameter int NB_ADDR = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic               i_MEM_unsigned,
  input  logic [1:0]         i_MEM_byte_half_word,
  input  logic [4:0]         i_write_reg,
  input  logic [31:0]        i_ALU_result,
  input  logic [31:0]        i_data_to_write_in_MEM,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic [4:0]         o_write_reg,
  output logic [31:0]        o_ALU_result,
  output logic [31:0]        o_mem_data,
  output logic [31:0]        o_debug_data,
  output logic               o_ready
);

  localparam int DEPTH = 1 << NB_ADDR;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t               state, state_next;
  logic [NB_ADDR-1:0]   clr_cnt, clr_cnt_next;
  logic                 clr_we;
  logic                 advance;
  logic [31:0]          mem [DEPTH];

  logic [NB_ADDR-1:0]   word_idx;
  logic [1:0]           lane;
  logic [31:0]          rd_word;
  logic [3:0]           byte_en;
  logic [31:0]          wr_data;
  logic [31:0]          wr_word;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_ext;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_we       = 1'b0;
    case (state)
      CLEAR: begin
        clr_we       = 1'b1;
        clr_cnt_next = clr_cnt + 1'b1;
        if (&clr_cnt) state_next = RUN;
      end
      default: ;
    endcase
  end

  assign advance  = (state == RUN) && !i_halt;
  assign o_ready  = (state == RUN);
  assign word_idx = i_ALU_result[NB_ADDR+1:2];
  assign lane     = i_ALU_result[1:0];
  assign rd_word  = mem[word_idx];

  // Halfword ignores addr[0] and word ignores addr[1:0]; misalignment is silently absorbed.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = i_data_to_write_in_MEM;
    case (i_MEM_byte_half_word)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{i_data_to_write_in_MEM[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{i_data_to_write_in_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_comb begin
    ld_byte = rd_word[7:0];
    case (lane)
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      2'd3:    ld_byte = rd_word[31:24];
      default: ld_byte = rd_word[7:0];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (i_MEM_byte_half_word)
      2'b00:   ld_ext = i_MEM_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = i_MEM_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  // Storage has no reset; the clear sweep owns initialisation.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (advance && i_MEM_write) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_WB_write      <= 1'b0;
      o_WB_mem_to_reg <= 1'b0;
      o_write_reg     <= '0;
      o_ALU_result    <= '0;
      o_mem_data      <= '0;
    end else if (advance) begin
      o_WB_write      <= i_WB_write;
      o_WB_mem_to_reg <= i_WB_mem_to_reg;
      o_write_reg     <= i_write_reg;
      o_ALU_result    <= i_ALU_result;
      o_mem_data      <= i_MEM_read ? ld_ext : 32'd0;
    end
  end

  assign o_debug_data = mem[i_debug_addr];

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// traffic checked against a byte-array reference model.
module tb_memory_access;

  localparam int NB_ADDR = 8;
  localparam int DEPTH   = 1 << NB_ADDR;
  localparam int NBYTES  = DEPTH * 4;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_halt;
  logic               i_WB_write, i_WB_mem_to_reg;
  logic               i_MEM_read, i_MEM_write, i_MEM_unsigned;
  logic [1:0]         i_MEM_byte_half_word;
  logic [4:0]         i_write_reg;
  logic [31:0]        i_ALU_result, i_data_to_write_in_MEM;
  logic [NB_ADDR-1:0] i_debug_addr;
  logic               o_WB_write, o_WB_mem_to_reg;
  logic [4:0]         o_write_reg;
  logic [31:0]        o_ALU_result, o_mem_data, o_debug_data;
  logic               o_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mbytes [NBYTES];
  logic        e_wbw, e_mtr;
  logic [4:0]  e_reg;
  logic [31:0] e_alu, e_mem;

  memory_access #(.NB_ADDR(NB_ADDR)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_WB_write(i_WB_write), .i_WB_mem_to_reg(i_WB_mem_to_reg),
    .i_MEM_read(i_MEM_read), .i_MEM_write(i_MEM_write), .i_MEM_unsigned(i_MEM_unsigned),
    .i_MEM_byte_half_word(i_MEM_byte_half_word), .i_write_reg(i_write_reg),
    .i_ALU_result(i_ALU_result), .i_data_to_write_in_MEM(i_data_to_write_in_MEM),
    .i_debug_addr(i_debug_addr),
    .o_WB_write(o_WB_write), .o_WB_mem_to_reg(o_WB_mem_to_reg), .o_write_reg(o_write_reg),
    .o_ALU_result(o_ALU_result), .o_mem_data(o_mem_data), .o_debug_data(o_debug_data),
    .o_ready(o_ready)
  );

  always #5 i_clk = ~i_clk;

  function automatic int access_size(input logic [1:0] bhw);
    return (bhw == 2'b00) ? 1 : (bhw == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_word(input int k);
    return {mbytes[4*k+3], mbytes[4*k+2], mbytes[4*k+1], mbytes[4*k]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] bhw,
                                             input logic uns);
    int size = access_size(bhw);
    int base = int'(addr % NBYTES);
    logic [31:0] val = 32'd0;
    base = base - (base % size);
    for (int i = 0; i < size; i++) val = val | (32'(mbytes[base+i]) << (8*i));
    if (!uns && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
    return val;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] bhw,
                             input logic [31:0] data);
    int size = access_size(bhw);
    int base = int'(addr % NBYTES);
    base = base - (base % size);
    for (int i = 0; i < size; i++) mbytes[base+i] = data[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    e_wbw = 0; e_mtr = 0; e_reg = '0; e_alu = '0; e_mem = '0;
  endtask

  task automatic set_idle();
    i_halt = 0; i_WB_write = 0; i_WB_mem_to_reg = 0;
    i_MEM_read = 0; i_MEM_write = 0; i_MEM_unsigned = 0;
    i_MEM_byte_half_word = 2'b11; i_write_reg = '0;
    i_ALU_result = '0; i_data_to_write_in_MEM = '0; i_debug_addr = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Waits out the clear sweep while hammering stores that must be dropped.
  task automatic wait_clear(input string tag);
    int cycles = 0;
    int bad_out = 0;
    int bad_words = 0;
    @(negedge i_clk);
    i_reset = 0;
    i_MEM_write = 1; i_MEM_byte_half_word = 2'b11; i_ALU_result = 32'h0000_0004;
    i_data_to_write_in_MEM = 32'hFFFF_FFFF; i_WB_write = 1; i_write_reg = 5'd7;
    while (!o_ready && cycles < 2000) begin
      tick();
      cycles++;
      if (o_WB_write !== 0 || o_write_reg !== 0 || o_ALU_result !== 0 || o_mem_data !== 0)
        bad_out++;
    end
    set_idle();
    checks++;
    if (cycles !== DEPTH) begin
      errors++;
      $display("FAIL %s_clear_len got %0d cycles expected %0d", tag, cycles, DEPTH);
    end
    checks++;
    if (bad_out !== 0) begin
      errors++;
      $display("FAIL %s_outputs_during_clear got %0d nonzero samples expected 0", tag, bad_out);
    end
    for (int k = 0; k < DEPTH; k++) begin
      i_debug_addr = NB_ADDR'(k);
      #1;
      if (o_debug_data !== 32'd0) bad_words++;
    end
    checks++;
    if (bad_words !== 0) begin
      errors++;
      $display("FAIL %s_memory_cleared got %0d nonzero words expected 0", tag, bad_words);
    end
    model_clear();
  endtask

  task automatic test_reset();
    set_idle();
    i_reset = 1;
    #12;
    checks++;
    if ({o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result, o_mem_data, o_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got alu=%h mem=%h rdy=%b expected all 0",
               o_ALU_result, o_mem_data, o_ready);
    end
    wait_clear("por");
  endtask

  task automatic test_loads_stores();
    i_MEM_write = 1; i_MEM_byte_half_word = 2'b11;
    i_ALU_result = 32'h10; i_data_to_write_in_MEM = 32'hDEAD_BEEF;
    tick(); model_store(32'h10, 2'b11, 32'hDEAD_BEEF);
    i_MEM_write = 0; i_MEM_read = 1;
    tick();
    checks++;
    if (o_mem_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_word got %h expected deadbeef", o_mem_data);
    end
    i_MEM_read = 0; i_MEM_write = 1; i_MEM_byte_half_word = 2'b00;
    i_ALU_result = 32'h11; i_data_to_write_in_MEM = 32'h0000_007F;
    tick(); model_store(32'h11, 2'b00, 32'h7F);
    i_MEM_write = 0; i_MEM_read = 1; i_ALU_result = 32'h13; i_debug_addr = 8'd4;
    tick();
    checks++;
    if (o_mem_data !== 32'hFFFF_FFDE) begin
      errors++; $display("FAIL load_byte_signed got %h expected ffffffde", o_mem_data);
    end
    checks++;
    if (o_debug_data !== 32'hDEAD_7FEF) begin
      errors++; $display("FAIL debug_word4 got %h expected dead7fef", o_debug_data);
    end
    i_MEM_unsigned = 1; i_ALU_result = 32'h11;
    tick();
    checks++;
    if (o_mem_data !== 32'h0000_007F) begin
      errors++; $display("FAIL load_byte_unsigned got %h expected 0000007f", o_mem_data);
    end
    i_MEM_unsigned = 0; i_MEM_byte_half_word = 2'b01; i_ALU_result = 32'h12;
    tick();
    checks++;
    if (o_mem_data !== 32'hFFFF_DEAD) begin
      errors++; $display("FAIL load_half_signed got %h expected ffffdead", o_mem_data);
    end
  endtask

  task automatic test_halt();
    i_halt = 1; i_MEM_read = 0; i_MEM_write = 1; i_MEM_byte_half_word = 2'b01;
    i_ALU_result = 32'h16; i_data_to_write_in_MEM = 32'hAAAA_1234;
    i_WB_write = 1; i_write_reg = 5'd3; i_debug_addr = 8'd5;
    tick(); tick();
    checks++;
    if (o_debug_data !== 32'd0) begin
      errors++; $display("FAIL halt_no_store got %h expected 00000000", o_debug_data);
    end
    checks++;
    if (o_mem_data !== 32'hFFFF_DEAD || o_ALU_result !== 32'h12 || o_WB_write !== 0) begin
      errors++;
      $display("FAIL halt_outputs_held got mem=%h alu=%h wbw=%b expected ffffdead 00000012 0",
               o_mem_data, o_ALU_result, o_WB_write);
    end
    i_debug_addr = 8'd4;
    #1;
    checks++;
    if (o_debug_data !== 32'hDEAD_7FEF) begin
      errors++; $display("FAIL halt_debug_live got %h expected dead7fef", o_debug_data);
    end
    i_debug_addr = 8'd5; i_halt = 0;
    tick(); model_store(32'h16, 2'b01, 32'hAAAA_1234);
    checks++;
    if (o_debug_data !== 32'h1234_0000 || o_ALU_result !== 32'h16) begin
      errors++;
      $display("FAIL halt_release_store got word5=%h alu=%h expected 12340000 00000016",
               o_debug_data, o_ALU_result);
    end
  endtask

  task automatic test_rtype();
    set_idle();
    i_ALU_result = 32'h42; i_write_reg = 5'd9; i_WB_write = 1; i_WB_mem_to_reg = 1;
    tick();
    checks++;
    if (o_ALU_result !== 32'h42 || o_write_reg !== 5'd9 || o_WB_write !== 1 ||
        o_WB_mem_to_reg !== 1 || o_mem_data !== 32'd0) begin
      errors++;
      $display("FAIL rtype_pass got alu=%h reg=%0d wbw=%b mtr=%b mem=%h expected 42 9 1 1 0",
               o_ALU_result, o_write_reg, o_WB_write, o_WB_mem_to_reg, o_mem_data);
    end
  endtask

  task automatic test_read_write_same();
    logic [31:0] old;
    set_idle();
    old = model_word(4);
    i_MEM_read = 1; i_MEM_write = 1; i_ALU_result = 32'h10;
    i_data_to_write_in_MEM = 32'h0BAD_F00D; i_debug_addr = 8'd4;
    tick(); model_store(32'h10, 2'b11, 32'h0BAD_F00D);
    checks++;
    if (o_mem_data !== old || o_debug_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL read_write_same got mem=%h word=%h expected %h 0badf00d",
               o_mem_data, o_debug_data, old);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] addr, data;
    logic [1:0]  bhw;
    logic        rd, wr, uns, halt;
    int          dbg;
    for (int t = 0; t < n; t++) begin
      halt = (t > 0) && ($urandom_range(0, 9) == 0);
      rd   = 1'($urandom); wr = 1'($urandom); uns = 1'($urandom);
      bhw  = 2'($urandom);
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      data = $urandom;
      dbg  = $urandom_range(0, 15);
      i_halt = halt; i_MEM_read = rd; i_MEM_write = wr; i_MEM_unsigned = uns;
      i_MEM_byte_half_word = bhw; i_ALU_result = addr; i_data_to_write_in_MEM = data;
      i_WB_write = 1'($urandom); i_WB_mem_to_reg = 1'($urandom); i_write_reg = 5'($urandom);
      i_debug_addr = NB_ADDR'(dbg);
      if (!halt) begin
        e_wbw = i_WB_write; e_mtr = i_WB_mem_to_reg; e_reg = i_write_reg; e_alu = addr;
        e_mem = rd ? model_load(addr, bhw, uns) : 32'd0;
        if (wr) model_store(addr, bhw, data);
      end
      tick();
      checks++;
      if (o_mem_data !== e_mem) begin
        errors++;
        $display("FAIL rand_mem_data t=%0d got %h expected %h", t, o_mem_data, e_mem);
      end
      checks++;
      if (o_ALU_result !== e_alu || o_write_reg !== e_reg || o_WB_write !== e_wbw ||
          o_WB_mem_to_reg !== e_mtr) begin
        errors++;
        $display("FAIL rand_ctrl t=%0d got alu=%h reg=%0d wbw=%b mtr=%b expected %h %0d %b %b",
                 t, o_ALU_result, o_write_reg, o_WB_write, o_WB_mem_to_reg,
                 e_alu, e_reg, e_wbw, e_mtr);
      end
      checks++;
      if (o_debug_data !== model_word(dbg)) begin
        errors++;
        $display("FAIL rand_debug t=%0d word=%0d got %h expected %h",
                 t, dbg, o_debug_data, model_word(dbg));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    set_idle();
    i_MEM_write = 1; i_ALU_result = 32'h20; i_data_to_write_in_MEM = 32'h5555_AAAA;
    i_WB_write = 1; i_write_reg = 5'd1;
    @(posedge i_clk);
    #2;
    i_reset = 1;
    #1;
    checks++;
    if ({o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result, o_mem_data, o_ready} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs got alu=%h reg=%0d rdy=%b expected all 0",
               o_ALU_result, o_write_reg, o_ready);
    end
    repeat (2) @(posedge i_clk);
    wait_clear("midrun");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_loads_stores();
    test_halt();
    test_rtype();
    test_read_write_same();
    test_random(400);
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter NB_ADDR, default 8, word-address width; data memory depth is 2^NB_ADDR 32-bit words.
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_halt  in  1  pipeline freeze; 1 = hold all registers, suppress memory writes.
REQ-005 i_WB_write, i_WB_mem_to_reg  in  1 each  control from EX, forwarded to WB.
REQ-006 i_MEM_read, i_MEM_write, i_MEM_unsigned  in  1 each  load, store, 1 = zero-extend loads.
REQ-007 i_MEM_byte_half_word  in  2  00 byte, 01 halfword, 11 word; 10 treated as word.
REQ-008 i_write_reg  in  5  destination register from EX.
REQ-009 i_ALU_result  in  32  byte address for loads/stores; ALU value for R/I-type.
REQ-010 i_data_to_write_in_MEM  in  32  store data.
REQ-011 i_debug_addr  in  NB_ADDR  debug word index.
REQ-012 o_WB_write, o_WB_mem_to_reg  out  1 each  registered control to WB.
REQ-013 o_write_reg  out  5  registered destination register.
REQ-014 o_ALU_result  out  32  registered ALU value.
REQ-015 o_mem_data  out  32  registered, extended load data.
REQ-016 o_debug_data  out  32  combinational read of word i_debug_addr.
REQ-017 o_ready  out  1  1 = memory initialised and accepting accesses.

Function
REQ-018 Word index = i_ALU_result[NB_ADDR+1:2]; byte lane = i_ALU_result[1:0]; upper address bits ignored.
REQ-019 FSM states CLEAR and RUN; reset forces CLEAR with clear counter = 0.
REQ-020 CLEAR: each cycle write 0 to word[counter], counter += 1; on counter = 2^NB_ADDR-1 write then go RUN; i_halt ignored in CLEAR.
REQ-021 o_ready = 1 only in RUN; in CLEAR all pipeline outputs hold reset values and store requests are dropped.
REQ-022 RUN store (i_MEM_write=1, i_halt=0): byte writes lane [1:0] with data[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with data[15:0]; word writes all lanes; other lanes unchanged.
REQ-023 Misalignment: halfword ignores addr[0], word ignores addr[1:0]; no exception.
REQ-024 Memory read is combinational from the addressed word; store takes effect at the rising edge ending its cycle, so a load in the next cycle sees stored data.
REQ-025 Load extraction: byte selects lane addr[1:0], half selects lane pair addr[1]; sign-extend when i_MEM_unsigned=0, zero-extend when 1.
REQ-026 o_mem_data captures extracted value when i_MEM_read=1, else captures 0.
REQ-027 RUN, i_halt=0: all o_* pipeline registers capture their inputs each edge; latency one cycle.
REQ-028 i_halt=1: all registers and memory hold; o_debug_data remains live.
REQ-029 i_MEM_read and i_MEM_write both 1: store performed, o_mem_data reflects pre-store word.
REQ-030 o_debug_data reads memory in every state, including during CLEAR (shows partially cleared contents).

Reset
REQ-031 Asynchronous reset clears o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result, o_mem_data to 0, o_ready to 0, state to CLEAR, counter to 0.
REQ-032 Reset asserted mid-CLEAR or mid-RUN restarts the full clear sweep after release; memory contents undefined until o_ready=1.

Verification
REQ-033 Reset release -> o_ready=0 for exactly 2^NB_ADDR cycles then 1; every o_debug_data word = 0.
REQ-034 Store word 0xDEADBEEF at addr 0x10, next cycle load word 0x10 -> o_mem_data=0xDEADBEEF one cycle after load issued.
REQ-035 After REQ-034 store byte 0x7F at 0x11; load byte signed 0x13 -> 0xFFFFFFDE; load byte unsigned 0x11 -> 0x0000007F; load half signed 0x12 -> 0xFFFFDEAD.
REQ-036 Store half 0x1234 at 0x16 with i_halt=1 -> debug word 5 unchanged, outputs held; drop halt -> word 5 = 0x1234xxxx upper half written.
REQ-037 R-type pass-through: i_ALU_result=0x00000042, i_write_reg=9, i_WB_write=1, i_WB_mem_to_reg=1 -> next cycle same on outputs, o_mem_data=0.
REQ-038 Assert i_reset during a store mid-RUN -> outputs 0 immediately, o_ready=0, memory re-cleared to 0.
